ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
// PURPOSE
//   Receives PS/2 keyboard frames (set-2 scan codes) and drives the key interface consumed by the game FSM.
//   tasta = last make code; done = level, high while that key is held.
//   The consumer latches tasta whenever done is high, so a held key repeats.
//   Sits between the board PS/2 pins and the game logic. One clock domain; PS/2 lines are asynchronous inputs.
// PARAMETERS
//   CLK_FREQ_HZ   25_000_000  system clock frequency
//   TIMEOUT_US    100         max gap between PS/2 clock falling edges inside one frame
//   FILTER_LEN    8           consecutive equal samples needed to accept a ps2_clk level change
//   TIMEOUT_CYC   derived     CLK_FREQ_HZ/1_000_000*TIMEOUT_US (localparam)
// PORTS
//   clock      in   1  system clock, rising edge
//   reset      in   1  asynchronous, active-low
//   ps2_clk    in   1  PS/2 clock pin, async, idle high
//   ps2_data   in   1  PS/2 data pin, async, idle high
//   tasta      out  8  last accepted make code
//   done       out  1  high while key tasta is held
//   extended   out  1  tasta was preceded by the E0 prefix
//   frame_err  out  1  one-cycle pulse on a parity, stop or timeout error
// BEHAVIOUR
//   Reset values: tasta=8'h00, done=0, extended=0, frame_err=0. The bit FSM goes to IDLE and all prefix flags clear.
//   Reset is honoured mid-frame; the partial frame is dropped.
//   Input path: 2-flop synchroniser on both pins, then a FILTER_LEN glitch filter on ps2_clk.
//   A falling edge is a filtered 1->0 transition. ps2_data (synchronised) is sampled in that same cycle.
//   Frame format: start(0), D0..D7 LSB first, odd parity, stop(1). 11 falling edges per frame.
//   Bit FSM:
//     IDLE   -> DATA on an edge with data=0. data=1 at an edge: ignore, stay IDLE.
//     DATA   shifts 8 bits with a 3-bit counter -> PARITY.
//     PARITY checks that the 9 bits (D0..D7 + parity) hold an odd number of ones -> STOP.
//     STOP   data=1 and parity ok: byte_valid pulse, 1 cycle. Otherwise frame_err pulse. Either way -> IDLE.
//   Timeout: outside IDLE, a counter clears on every edge.
//     Reaching TIMEOUT_CYC -> frame_err pulse, go to IDLE, byte dropped, prefix flags cleared.
//   Code decoder (acts on byte_valid):
//     E0 -> set ext_pend.
//     F0 -> set brk_pend.
//     Any other byte b, with brk_pend set (a break):
//       if b==tasta and ext_pend==extended, done<=0; otherwise no output change.
//       Clear both pending flags.
//     Any other byte b, without brk_pend (a make):
//       tasta<=b, extended<=ext_pend, done<=1, clear ext_pend.
//     A make of a new key while another is held replaces tasta; done stays 1.
//   Latency: tasta/done/extended update 1 clock after the stop-bit edge cycle. frame_err is asserted in that same cycle.
//   A parity or stop error also clears ext_pend and brk_pend.
//   Simultaneous timeout and edge in one cycle: the edge wins and the counter clears.
//   Host-to-device transmission is not supported. Both pins are input-only.
// STRUCTURE
//   Shared package pong_pkg:
//     scan-code constants SC_BREAK=8'hF0, SC_EXT=8'hE0.
//     key codes already used by the game: 1C 23 3B 4B 76 29 16 1E 2D 34 32.
//     bit-FSM state encoding.
//   Sub-module ps2_frame_rx: sync, filter, bit FSM, timeout. Outputs byte[7:0], byte_valid, frame_err.
//   ps2_keyboard_rx holds the prefix/break decoder and the output registers.
// TESTING
//   Bench: PS/2 clock 12.5 kHz. Data changes mid-high-phase.
//   1 Make A: frame 0x1C, parity 0 -> tasta=1C, done=1, extended=0. Then F0,1C -> done=0, tasta stays 1C.
//   2 Held key: make 1C, then F0,23 -> done stays 1. Then make 29 -> tasta=29, done=1.
//   3 Extended: E0,75 -> tasta=75, extended=1. Then E0,F0,75 -> done=0.
//   4 Bad parity: 0x29 sent with parity=1 -> one frame_err pulse; tasta and done unchanged.
//     Then valid 0x16 -> tasta=16.
//   5 Timeout: 5 bits sent, then 120 us idle -> frame_err pulse, FSM in IDLE. Next full frame 0x1E accepted.
//   6 Glitches and reset: 3-cycle low glitch on ps2_clk -> no bit consumed.
//     reset low mid-frame -> all outputs 0. Following frame 0x2D -> tasta=2D, done=1.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong keyboard path: scan codes, bit-FSM encoding
// and the frame receiver's response record.
package pong_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;

  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_J     = 8'h3B;
  localparam logic [7:0] KEY_L     = 8'h4B;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_R     = 8'h2D;
  localparam logic [7:0] KEY_G     = 8'h34;
  localparam logic [7:0] KEY_B     = 8'h32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  typedef struct packed {
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;
  } ps2_frame_t;

  // True when data bits plus parity bit carry an odd number of ones.
  function automatic logic odd_parity(input logic [8:0] v);
    return ^v;
  endfunction

  function automatic logic is_game_key(input logic [7:0] b);
    return (b == KEY_A) || (b == KEY_D) || (b == KEY_J) || (b == KEY_L) ||
           (b == KEY_ESC) || (b == KEY_SPACE) || (b == KEY_1) ||
           (b == KEY_2) || (b == KEY_R) || (b == KEY_G) || (b == KEY_B);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, ps2_clk glitch
// filter, 11-bit frame FSM and inter-edge timeout.
module ps2_frame_rx
  import pong_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2500,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output ps2_frame_t rx
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic          clk_flt;
  logic [FW-1:0] flt_cnt;
  logic          flt_flip, fall;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] to_cnt;
  logic          timeout, stop_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // The filtered level only follows the pin after FILTER_LEN consecutive
  // samples that disagree with it; any agreeing sample restarts the run.
  assign flt_flip = (clk_s != clk_flt) && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall     = flt_flip && clk_flt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_flt <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s == clk_flt) begin
      flt_cnt <= '0;
    end else if (flt_flip) begin
      clk_flt <= clk_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // An edge in the same cycle as expiry wins, so the check excludes fall.
  assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE || fall || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_ok  <= 1'b0;
    end else if (timeout) begin
      state <= ST_IDLE;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!data_s) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          shreg   <= {data_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state <= ST_PARITY;
        end
        ST_PARITY: begin
          par_ok <= odd_parity({data_s, shreg});
          state  <= ST_STOP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stop_ok = data_s && par_ok;

  always_comb begin
    rx            = '0;
    rx.byte_data  = shreg;
    rx.byte_valid = fall && (state == ST_STOP) && stop_ok;
    rx.frame_err  = timeout || (fall && (state == ST_STOP) && !stop_ok);
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard front end for the game FSM: turns set-2 scan-code bytes into
// a held-key interface (tasta/done/extended) plus a frame error pulse.
module ps2_keyboard_rx
  import pong_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int TIMEOUT_US  = 100,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] tasta,
  output logic       done,
  output logic       extended,
  output logic       frame_err
);

  localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;

  ps2_frame_t rx;
  logic       ext_pend, brk_pend;

  ps2_frame_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FILTER_LEN  (FILTER_LEN)
  ) u_frame (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (rx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tasta     <= 8'h00;
      done      <= 1'b0;
      extended  <= 1'b0;
      frame_err <= 1'b0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
    end else begin
      frame_err <= rx.frame_err;
      if (rx.frame_err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (rx.byte_valid) begin
        if (rx.byte_data == SC_EXT) begin
          ext_pend <= 1'b1;
        end else if (rx.byte_data == SC_BREAK) begin
          brk_pend <= 1'b1;
        end else if (brk_pend) begin
          // Releasing a key other than the one shown leaves the output alone.
          if (rx.byte_data == tasta && ext_pend == extended) done <= 1'b0;
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end else begin
          tasta    <= rx.byte_data;
          extended <= ext_pend;
          done     <= 1'b1;
          ext_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: a table of scan-code frames with expected
// key outputs, then hand-built timeout, glitch and mid-frame reset sequences.
`timescale 1ns/1ns
module tb_ps2_keyboard_rx;

  // 1 MHz system clock keeps the 12.5 kHz PS/2 frames short in cycles.
  localparam int CLK_FREQ_HZ = 1_000_000;
  localparam int TIMEOUT_US  = 100;
  localparam int FILTER_LEN  = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] tasta;
  logic       done, extended, frame_err;

  int n_chk  = 0;
  int n_fail = 0;
  int err_cnt = 0;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic [7:0] exp_tasta;
    logic       exp_done;
    logic       exp_ext;
    int         exp_errs;
  } vec_t;

  vec_t tbl[14];

  ps2_keyboard_rx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .TIMEOUT_US  (TIMEOUT_US),
    .FILTER_LEN  (FILTER_LEN)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .tasta     (tasta),
    .done      (done),
    .extended  (extended),
    .frame_err (frame_err)
  );

  always #500 clock = ~clock;

  // Counts cycles with frame_err high, so a stuck or stretched pulse shows up.
  always @(posedge clock) if (frame_err === 1'b1) err_cnt <= err_cnt + 1;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] c, input logic bad);
    logic p;
    p = ~(^c) ^ bad;
    return {1'b1, p, c, 1'b0};
  endfunction

  // One PS/2 bit per 80 us: data changes 20 us into the high phase,
  // optionally with a 3-cycle low glitch on ps2_clk before the real fall.
  task automatic send_bits(input logic [10:0] f, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      if (i == glitch_at) begin
        wait_cyc(6);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(11);
      end else begin
        wait_cyc(20);
      end
      ps2_clk = 1'b0;
      wait_cyc(40);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic bad);
    send_bits(mk_frame(c, bad), 11, -1);
    wait_cyc(30);
  endtask

  task automatic chk_out(input string nm, input logic [7:0] t, input logic d,
                         input logic e, input int errs, input int e0);
    chk({nm, ".tasta"},    32'(tasta),          32'(t));
    chk({nm, ".done"},     32'(done),           32'(d));
    chk({nm, ".extended"}, 32'(extended),       32'(e));
    chk({nm, ".errs"},     32'(err_cnt - e0),   32'(errs));
  endtask

  initial begin
    int e0;
    tbl[0]  = '{8'h1C, 1'b0, 8'h1C, 1'b1, 1'b0, 0};
    tbl[1]  = '{8'hF0, 1'b0, 8'h1C, 1'b1, 1'b0, 0};
    tbl[2]  = '{8'h1C, 1'b0, 8'h1C, 1'b0, 1'b0, 0};
    tbl[3]  = '{8'h1C, 1'b0, 8'h1C, 1'b1, 1'b0, 0};
    tbl[4]  = '{8'hF0, 1'b0, 8'h1C, 1'b1, 1'b0, 0};
    tbl[5]  = '{8'h23, 1'b0, 8'h1C, 1'b1, 1'b0, 0};
    tbl[6]  = '{8'h29, 1'b0, 8'h29, 1'b1, 1'b0, 0};
    tbl[7]  = '{8'hE0, 1'b0, 8'h29, 1'b1, 1'b0, 0};
    tbl[8]  = '{8'h75, 1'b0, 8'h75, 1'b1, 1'b1, 0};
    tbl[9]  = '{8'hE0, 1'b0, 8'h75, 1'b1, 1'b1, 0};
    tbl[10] = '{8'hF0, 1'b0, 8'h75, 1'b1, 1'b1, 0};
    tbl[11] = '{8'h75, 1'b0, 8'h75, 1'b0, 1'b1, 0};
    tbl[12] = '{8'h29, 1'b1, 8'h75, 1'b0, 1'b1, 1};
    tbl[13] = '{8'h16, 1'b0, 8'h16, 1'b1, 1'b0, 0};

    wait_cyc(5);
    chk("reset.tasta",     32'(tasta),     32'h00);
    chk("reset.done",      32'(done),      32'h0);
    chk("reset.extended",  32'(extended),  32'h0);
    chk("reset.frame_err", 32'(frame_err), 32'h0);
    reset = 1'b1;
    wait_cyc(20);

    for (int i = 0; i < 14; i++) begin
      e0 = err_cnt;
      send_frame(tbl[i].code, tbl[i].bad_par);
      chk_out($sformatf("vec%0d", i), tbl[i].exp_tasta, tbl[i].exp_done,
              tbl[i].exp_ext, tbl[i].exp_errs, e0);
    end

    // Timeout mid-frame also drops a pending E0.
    send_frame(8'hE0, 1'b0);
    e0 = err_cnt;
    send_bits(mk_frame(8'h33, 1'b0), 5, -1);
    wait_cyc(120);
    chk_out("timeout", 8'h16, 1'b1, 1'b0, 1, e0);
    e0 = err_cnt;
    send_frame(8'h1E, 1'b0);
    chk_out("after_timeout", 8'h1E, 1'b1, 1'b0, 0, e0);

    e0 = err_cnt;
    send_bits(mk_frame(8'h34, 1'b0), 11, 3);
    wait_cyc(30);
    chk_out("glitch", 8'h34, 1'b1, 1'b0, 0, e0);

    // Reset lands in the middle of a frame after an E0 prefix.
    send_frame(8'hE0, 1'b0);
    send_bits(mk_frame(8'h4B, 1'b0), 6, -1);
    reset = 1'b0;
    wait_cyc(2);
    chk("midreset.tasta",     32'(tasta),     32'h00);
    chk("midreset.done",      32'(done),      32'h0);
    chk("midreset.extended",  32'(extended),  32'h0);
    chk("midreset.frame_err", 32'(frame_err), 32'h0);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(20);
    e0 = err_cnt;
    send_frame(8'h2D, 1'b0);
    chk_out("after_reset", 8'h2D, 1'b1, 1'b0, 0, e0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
